// File: rtl/io_cfg_pkg.sv
`default_nettype none
// =============================================================================
// Module  : io_cfg_pkg
// Brief   : Shared states and serial CRC-16-CCITT step for the I/O ccff sequencer
// Revision: 1.0 - initial release
// =============================================================================
package io_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISOLATE = 3'd1,
      ST_LOAD    = 3'd2,
      ST_ROTATE  = 3'd3,
      ST_CHECK   = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } cfg_state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // MSB-first serial update, one bit per call
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_crc16_serial.sv
`default_nettype none
// =============================================================================
// Module  : ccff_crc16_serial
// Brief   : Bit-serial CRC-16-CCITT accumulator with synchronous clear
// Revision: 1.0 - initial release
// =============================================================================
module ccff_crc16_serial
   import io_cfg_pkg::*;
(
   input  logic        prog_clk,
   input  logic        prog_reset,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   always_ff @(posedge prog_clk) begin
      if (prog_reset || clr) begin
         crc <= CRC16_INIT;
      end else if (en) begin
         crc <= crc16_step(crc, din);
      end
   end

endmodule
`default_nettype wire

// File: rtl/io_ccff_cfg_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : io_ccff_cfg_ctrl
// Brief   : Loads the I/O-tile ccff chain from host words, verifies it by
//           rotation + CRC, and releases pad isolation only on a match
// Revision: 1.0 - initial release
// =============================================================================
module io_ccff_cfg_ctrl
   import io_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 88,
   parameter int WORD_W    = 8,
   parameter int ISO_CYC   = 4
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic              isol_n,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam int ISO_W  = $clog2(ISO_CYC + 1);
   localparam int WCNT_W = $clog2(WORD_W + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [ISO_W-1:0]  ISO_LAST  = ISO_W'(ISO_CYC - 1);
   localparam logic [WCNT_W-1:0] WORD_BITS = WCNT_W'(WORD_W);
   localparam logic [WCNT_W-1:0] ONE_BIT   = WCNT_W'(1);

   cfg_state_t          state;
   logic [WORD_W-1:0]   word_buf;
   logic [WCNT_W-1:0]   buf_bits;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ISO_W-1:0]    iso_cnt;
   logic [15:0]         crc_in;
   logic [15:0]         crc_rd;
   logic                start_ok;
   logic                buf_full;
   logic                shift_en;
   logic                rot_en;

   assign buf_full    = (buf_bits != '0);
   assign start_ok    = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
   assign shift_en    = (state == ST_LOAD) && buf_full;
   assign rot_en      = (state == ST_ROTATE);
   assign ccff_clk_en = shift_en | rot_en;
   // Rotation feeds the tail straight back so the chain ends where it started
   assign ccff_head   = shift_en ? word_buf[0] : (rot_en ? ccff_tail : 1'b0);

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state     <= ST_IDLE;
         word_buf  <= '0;
         buf_bits  <= '0;
         bit_cnt   <= '0;
         iso_cnt   <= '0;
         cfg_ready <= 1'b0;
         isol_n    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state   <= ST_ISOLATE;
                  iso_cnt <= '0;
                  bit_cnt <= '0;
                  isol_n  <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  error   <= 1'b0;
               end
            end
            ST_ISOLATE: begin
               if (iso_cnt == ISO_LAST) begin
                  state     <= ST_LOAD;
                  cfg_ready <= 1'b1;
               end else begin
                  iso_cnt <= iso_cnt + 1'b1;
               end
            end
            ST_LOAD: begin
               if (cfg_valid && cfg_ready) begin
                  word_buf  <= cfg_data;
                  buf_bits  <= WORD_BITS;
                  cfg_ready <= 1'b0;
               end else if (buf_full) begin
                  word_buf <= word_buf >> 1;
                  // Last chain bit ends the load even mid-word; leftover bits are dropped
                  if (bit_cnt == LAST_BIT) begin
                     state    <= ST_ROTATE;
                     buf_bits <= '0;
                     bit_cnt  <= '0;
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     buf_bits  <= buf_bits - 1'b1;
                     cfg_ready <= (buf_bits == ONE_BIT);
                  end
               end
            end
            ST_ROTATE: begin
               if (bit_cnt == LAST_BIT) begin
                  state   <= ST_CHECK;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               busy <= 1'b0;
               if (crc_rd == crc_in) begin
                  state  <= ST_DONE;
                  done   <= 1'b1;
                  isol_n <= 1'b1;
               end else begin
                  state <= ST_ERROR;
                  error <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   ccff_crc16_serial u_crc_in (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .clr        (start_ok),
      .en         (shift_en),
      .din        (word_buf[0]),
      .crc        (crc_in)
   );

   ccff_crc16_serial u_crc_rd (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .clr        (start_ok),
      .en         (rot_en),
      .din        (ccff_tail),
      .crc        (crc_rd)
   );

endmodule
`default_nettype wire

// File: tb/tb_io_ccff_cfg_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_io_ccff_cfg_ctrl
// Brief   : Self-checking bench; a 12-bit and an 88-bit chain model driven by
//           two sequencer instances
// Revision: 1.0 - initial release
// =============================================================================
module tb_io_ccff_cfg_ctrl;

   localparam int LS  = 12;
   localparam int LL  = 88;
   localparam int W   = 8;
   localparam int ISO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_s = 1'b0, start_s = 1'b0, valid_s = 1'b0, flip_s = 1'b0;
   logic [W-1:0]  data_s = '0;
   logic          ready_s, head_s, en_s, tail_s, isol_s, busy_s, done_s, err_s;
   logic [LS-1:0] chain_s = '0;

   logic          rst_l = 1'b0, start_l = 1'b0, valid_l = 1'b0;
   logic [W-1:0]  data_l = '0;
   logic          ready_l, head_l, en_l, tail_l, isol_l, busy_l, done_l, err_l;
   logic [LL-1:0] chain_l = '0;

   logic [W-1:0]  wq [0:11];
   int            n_assert = 0;
   int            n_fail   = 0;

   io_ccff_cfg_ctrl #(.CHAIN_LEN(LS), .WORD_W(W), .ISO_CYC(ISO)) dut_s (
      .prog_clk(clk), .prog_reset(rst_s), .start(start_s), .cfg_data(data_s),
      .cfg_valid(valid_s), .cfg_ready(ready_s), .ccff_head(head_s),
      .ccff_clk_en(en_s), .ccff_tail(tail_s), .isol_n(isol_s), .busy(busy_s),
      .done(done_s), .error(err_s));

   io_ccff_cfg_ctrl #(.CHAIN_LEN(LL), .WORD_W(W), .ISO_CYC(ISO)) dut_l (
      .prog_clk(clk), .prog_reset(rst_l), .start(start_l), .cfg_data(data_l),
      .cfg_valid(valid_l), .cfg_ready(ready_l), .ccff_head(head_l),
      .ccff_clk_en(en_l), .ccff_tail(tail_l), .isol_n(isol_l), .busy(busy_l),
      .done(done_l), .error(err_l));

   // Chain models: head enters at bit 0, tail is the top bit
   assign tail_s = chain_s[LS-1];
   assign tail_l = chain_l[LL-1];
   always @(posedge clk) if (en_s) chain_s <= {chain_s[LS-2:0], head_s} ^ (flip_s ? LS'(32) : LS'(0));
   always @(posedge clk) if (en_l) chain_l <= {chain_l[LL-2:0], head_l};

   function automatic logic rdy (input bit big); return big ? ready_l : ready_s; endfunction
   function automatic logic en   (input bit big); return big ? en_l    : en_s;    endfunction
   function automatic logic isol (input bit big); return big ? isol_l  : isol_s;  endfunction
   function automatic logic busy (input bit big); return big ? busy_l  : busy_s;  endfunction
   function automatic logic dn   (input bit big); return big ? done_l  : done_s;  endfunction
   function automatic logic er   (input bit big); return big ? err_l   : err_s;   endfunction
   function automatic logic [127:0] chain_obs(input bit big);
      return big ? 128'(chain_l) : 128'(chain_s);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit big, input logic st, input logic v, input logic [W-1:0] d,
                        input logic r, input logic f);
      start_s = !big & st;  valid_s = !big & v;  data_s = big ? '0 : d;
      rst_s   = !big & r;   flip_s  = !big & f;
      start_l =  big & st;  valid_l =  big & v;  data_l = big ? d : '0;
      rst_l   =  big & r;
   endtask

   task automatic tick(); @(posedge clk); #1; endtask

   // One configuration session; the expected chain image is the first L stream bits
   task automatic session(input bit big, input int n_words, input int gap_after,
                          input int gap_len, input bit tamper, input int mid_start,
                          input int reset_k, output int lat, output logic [127:0] cexp);
      int L, idx, gap, en_cnt, cyc;
      bit gap_done, iso_bad, gap_bad, rdy_bad, f, r, v;
      L = big ? LL : LS;
      idx = 0; gap = 0; en_cnt = 0; cyc = 0;
      gap_done = 0; iso_bad = 0; gap_bad = 0; rdy_bad = 0;
      cexp = '0;
      for (int i = 0; i < L; i++) cexp[L-1-i] = wq[i/W][i%W];
      drive(big, 1, 0, '0, 0, 0);
      tick();
      drive(big, 0, 0, '0, 0, 0);
      chk("start_isol_n", isol(big), 0);
      chk("start_busy",   busy(big), 1);
      chk("start_done",   dn(big),   0);
      while (!(dn(big) || er(big)) && cyc < 1000) begin
         if (idx == gap_after && !gap_done && rdy(big)) begin
            gap = gap_len; gap_done = 1;
         end
         v = (gap == 0) && (idx < n_words);
         if (gap > 0) begin
            if (en(big) || !rdy(big)) gap_bad = 1;
            gap--;
         end
         if (isol(big)) iso_bad = 1;
         if (en_cnt >= L && rdy(big)) rdy_bad = 1;
         f = tamper && en_cnt == L + 2;
         r = reset_k > 0 && en(big) && en_cnt == L + reset_k - 1;
         drive(big, mid_start > 0 && cyc == mid_start, v, (idx < 12) ? wq[idx] : '0, r, f);
         if (v && rdy(big)) idx++;
         if (en(big)) en_cnt++;
         tick();
         cyc++;
         if (r) begin
            drive(big, 0, 0, '0, 0, 0);
            chk("rst_isol_n", isol(big), 0);
            chk("rst_busy",   busy(big), 0);
            chk("rst_clk_en", en(big),   0);
            chk("rst_ready",  rdy(big),  0);
            chk("rst_done",   dn(big),   0);
            lat = cyc;
            return;
         end
      end
      drive(big, 0, 0, '0, 0, 0);
      lat = cyc;
      chk("finished",    dn(big) | er(big), 1);
      chk("words_taken", idx, (L + W - 1) / W);
      chk("isol_during", iso_bad, 0);
      chk("gap_stall",   gap_bad, 0);
      chk("ready_after", rdy_bad, 0);
   endtask

   task automatic expect_ok(input bit big, input int gap_len, input int lat,
                            input logic [127:0] cexp);
      int L;
      L = big ? LL : LS;
      chk("done",    dn(big),   1);
      chk("error",   er(big),   0);
      chk("isol_n",  isol(big), 1);
      chk("busy",    busy(big), 0);
      chk("latency", lat, ISO + (L + W - 1) / W + 2 * L + 1 + gap_len);
      chk("chain",   chain_obs(big), cexp);
   endtask

   initial begin
      int lat;
      logic [127:0] cexp;
      logic [LS-1:0] rev;

      drive(0, 0, 0, '0, 1, 0);
      rst_l = 1'b1;
      tick(); tick();
      chk("rst_isol_n",  isol_s,  0);
      chk("rst_ready",   ready_s, 0);
      chk("rst_clk_en",  en_s,    0);
      chk("rst_head",    head_s,  0);
      chk("rst_busy",    busy_s,  0);
      chk("rst_done",    done_s,  0);
      chk("rst_error",   err_s,   0);
      chk("rst_l_flags", {isol_l, ready_l, en_l, busy_l, done_l, err_l}, 6'b0);
      drive(0, 0, 0, '0, 0, 0);
      rst_l = 1'b0;
      tick();

      // Directed stream from the plan
      wq[0] = 8'hA5; wq[1] = 8'h03;
      session(0, 2, -1, 0, 0, 0, 0, lat, cexp);
      expect_ok(0, 0, lat, cexp);
      for (int i = 0; i < LS; i++) rev[i] = chain_s[LS-1-i];
      chk("chain_3a5", rev, 12'h3A5);

      // Corrupt the chain during rotation: verification must fail
      wq[0] = W'($urandom); wq[1] = W'($urandom);
      session(0, 2, -1, 0, 1, 0, 0, lat, cexp);
      chk("tamper_error",  err_s,  1);
      chk("tamper_done",   done_s, 0);
      chk("tamper_isol_n", isol_s, 0);
      chk("tamper_lat",    lat, ISO + 2 + 2 * LS + 1);

      // Clean session started from ERROR
      wq[0] = W'($urandom); wq[1] = W'($urandom);
      session(0, 2, -1, 0, 0, 0, 0, lat, cexp);
      expect_ok(0, 0, lat, cexp);

      // Seven-cycle valid gap between the two words
      wq[0] = W'($urandom); wq[1] = W'($urandom);
      session(0, 2, 1, 7, 0, 0, 0, lat, cexp);
      expect_ok(0, 7, lat, cexp);

      // Start pulsed mid-LOAD must not disturb the session
      wq[0] = W'($urandom); wq[1] = W'($urandom);
      session(0, 2, -1, 0, 0, ISO + 3, 0, lat, cexp);
      expect_ok(0, 0, lat, cexp);

      // Reset during rotation cycle 3, then idle, then a clean recovery
      session(0, 2, -1, 0, 0, 0, 3, lat, cexp);
      tick(); tick(); tick();
      chk("idle_clk_en", en_s,   0);
      chk("idle_busy",   busy_s, 0);
      chk("idle_isol_n", isol_s, 0);
      wq[0] = W'($urandom); wq[1] = W'($urandom);
      session(0, 2, -1, 0, 0, 0, 0, lat, cexp);
      expect_ok(0, 0, lat, cexp);

      // 88-bit chain: 12 words offered, only 11 may be taken
      for (int i = 0; i < 12; i++) wq[i] = W'($urandom);
      session(1, 12, -1, 0, 0, 0, 0, lat, cexp);
      expect_ok(1, 0, lat, cexp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_ccff_cfg_ctrl.md
Name: io_ccff_cfg_ctrl

Overview:
Configuration sequencer for the I/O-tile configuration chain (ccff_head → … → ccff_tail) and the pad isolation control (isol_n).
- Accepts a bitstream from the host as words, isolates the pads, serializes the bits into the chain, then rotates the chain once to verify it with a CRC.
- Releases isolation only after verification passes.
- Sits between the SoC-side config port and the top-level I/O ring.

Parameters:
CHAIN_LEN, 88, number of config flops in the I/O ccff chain (≥2)
WORD_W, 8, host word width; bits shifted LSB first
ISO_CYC, 4, cycles isol_n is held low before shifting begins (≥1)

Ports:
prog_clk  in  1  configuration clock; all state on rising edge
prog_reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a configuration session (honoured in IDLE/DONE/ERROR only)
cfg_data  in  WORD_W  bitstream word
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  controller accepts word this cycle
ccff_head  out  1  serial bit into chain
ccff_clk_en  out  1  chain advances at this prog_clk edge (drives external clock gate)
ccff_tail  in  1  serial bit out of chain (combinational from last flop)
isol_n  out  1  0 = pads isolated, 1 = pads live
busy  out  1  session in progress
done  out  1  level; chain loaded and verified
error  out  1  level; CRC mismatch

Behaviour:
- Clocking: one clock, prog_clk. Reset is synchronous and active-high on prog_reset.
- Reset values: state=IDLE; isol_n=0; cfg_ready=0; ccff_clk_en=0; ccff_head=0; busy=0; done=0; error=0; counters=0; both CRCs=0xFFFF.
- Outputs are registered except ccff_head and ccff_clk_en, which are decoded from state and the shift register.
- States:
  - IDLE: isol_n=0. start → ISOLATE.
  - ISOLATE: isol_n=0, busy=1. Stays ISO_CYC cycles, then → LOAD.
  - LOAD:
    - cfg_ready=1 only while the word buffer is empty. Handshake = cfg_valid & cfg_ready; the word is captured at that edge.
    - Shifting starts the next cycle: one bit per cycle, ccff_clk_en=1, ccff_head=buf[0], buf >>= 1.
    - Each shifted bit is folded into crc_in.
    - One bubble cycle per word (accept cycle); cfg_ready=0 while shifting.
    - Buffer empties after WORD_W bits, or when the bit counter reaches CHAIN_LEN.
    - If CHAIN_LEN mod WORD_W ≠ 0, the upper bits of the last word are discarded.
    - cfg_valid low stalls with ccff_clk_en=0; no timeout.
    - After bit CHAIN_LEN-1 → ROTATE.
  - ROTATE:
    - CHAIN_LEN cycles with ccff_clk_en=1 and ccff_head=ccff_tail. This restores the chain contents.
    - ccff_tail is folded into crc_rd each cycle.
    - → CHECK.
  - CHECK: one cycle, ccff_clk_en=0. crc_rd==crc_in → DONE, else → ERROR.
  - DONE: isol_n=1, done=1, busy=0. start → ISOLATE; isol_n drops to 0 at the same edge and done clears.
  - ERROR: isol_n=0, error=1. start → ISOLATE and clears error.
- start while busy: ignored.
- prog_reset asserted mid-session: all outputs return to reset values at that edge; isol_n=0 takes priority over everything. Partial chain contents are don't-care.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, serial MSB-first update, no final XOR. Both CRCs reset to init on entry to ISOLATE.
- Counters: bit counter width $clog2(CHAIN_LEN+1), saturates, never wraps. ISO counter width $clog2(ISO_CYC+1).
- Latency (valid always high): start edge → done high = ISO_CYC + ceil(CHAIN_LEN/WORD_W) + 2·CHAIN_LEN + 1 cycles.

Decomposition:
- Package io_cfg_pkg:
  - state enum (IDLE, ISOLATE, LOAD, ROTATE, CHECK, DONE, ERROR)
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF
  - function crc16_step(crc, bit)
- Sub-module ccff_crc16_serial (ports: prog_clk, prog_reset, clr, en, din, crc[15:0]), instantiated twice (crc_in, crc_rd).
- The bench models the chain as a CHAIN_LEN-bit shift register clocked by prog_clk & ccff_clk_en.

Test Plan:
- CHAIN_LEN=12, WORD_W=8, ISO_CYC=4, valid held high, words 0xA5, 0x03 → chain holds 0x3A5 (bit0 at tail end), isol_n=0 throughout, done=1 and isol_n=1 exactly 31 cycles after the start edge, error=0.
- Same stream, bench model flips chain bit 5 during ROTATE → error=1, done=0, isol_n stays 0; a following start with a clean model → done=1.
- cfg_valid deasserted for 7 cycles between words → ccff_clk_en=0 throughout the gap, cfg_ready held 1, final chain contents and CRC still match, done latency +7.
- Default params (CHAIN_LEN=88, WORD_W=8), 11 random words → all 88 bits land in order; the 12th word offered is not accepted (cfg_ready=0 after bit 87).
- prog_reset pulsed during ROTATE cycle 3 → next cycle isol_n=0, busy=0, ccff_clk_en=0, state IDLE; start mid-LOAD ignored; start in DONE re-isolates at the same edge.
